div_unit: RTL and testbench

Multi-cycle signed 32-bit divider serving the multicycle CPU's DIV instruction. The control unit is the initiator: it pulses a start, waits for a done pulse, then loads the outputs into HI (remainder) and LO (quotient) through the HI/LO source muxes. The block also flags divide-by-zero, so the control unit can raise the exception path (EPC/PC) instead of writing HI/LO.

---
 rtl/div_unit.sv | 182 ++++++++++++++++++
 tb/tb_div_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle signed divider for the multicycle CPU's DIV instruction.
// Restoring division on operand magnitudes, one quotient bit per cycle (MSB
// first), followed by a sign-fix step. Quotient truncates toward zero and the
// remainder takes the dividend's sign; all arithmetic wraps modulo 2^W.
//
// Handshake: the control unit pulses Div_Start for one cycle while the block
// is idle (Div_Busy=0, Div_Done=0). Starts seen in any other state are dropped.
// Completion is a one-cycle Div_Done pulse; Div_HIOut/Div_LOOut are valid in
// that cycle and hold until the next successful (non-zero-divisor) completion.
// Div_Zero pulses together with Div_Done when the divisor was zero.
//
// Ports:
//   Clock, Reset      rising-edge clock, asynchronous active-low reset
//   Div_Start         one-cycle start request, sampled only in IDLE
//   Dividend, Divisor two's-complement operands, captured on the accepting edge
//   Div_HIOut         remainder (registered)
//   Div_LOOut         quotient (registered)
//   Div_Busy          high while in CALC or FIX
//   Div_Done          one-cycle completion pulse
//   Div_Zero          one-cycle divide-by-zero flag, coincident with Div_Done
//   dbg_state         current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Div_Start,
    input  logic [DATA_WIDTH-1:0] Dividend,
    input  logic [DATA_WIDTH-1:0] Divisor,
    output logic [DATA_WIDTH-1:0] Div_HIOut,
    output logic [DATA_WIDTH-1:0] Div_LOOut,
    output logic                  Div_Busy,
    output logic                  Div_Done,
    output logic                  Div_Zero,
    output logic [1:0]            dbg_state
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  zero_pend_q, zero_pend_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  zflag_q, zflag_d;

    // One extra bit so the trial subtraction's borrow tells us rem' < |divisor|.
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   rem_sub;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        zero_pend_d = zero_pend_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        zflag_d     = 1'b0;

        rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (Div_Start) begin
                    if (Divisor == '0) begin
                        // Zero divisor: skip the datapath, HI/LO untouched.
                        zero_pend_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        // The dividend magnitude is shifted out of quo while
                        // quotient bits shift in from the bottom.
                        quo_d       = Dividend[DATA_WIDTH-1] ? -Dividend : Dividend;
                        dvs_d       = Divisor[DATA_WIDTH-1]  ? -Divisor  : Divisor;
                        neg_quo_d   = Dividend[DATA_WIDTH-1] ^ Divisor[DATA_WIDTH-1];
                        neg_rem_d   = Dividend[DATA_WIDTH-1];
                        rem_d       = '0;
                        cnt_d       = '0;
                        zero_pend_d = 1'b0;
                        state_d     = S_CALC;
                    end
                end
            end
            S_CALC: begin
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
                if (!rem_sub[DATA_WIDTH]) begin
                    rem_d    = rem_sub[DATA_WIDTH-1:0];
                    quo_d[0] = 1'b1;
                end else begin
                    // rem' < |divisor| here, so its top bit is known zero.
                    rem_d = rem_shift[DATA_WIDTH-1:0];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Normal path: Done was raised on entry and drops now.
                // Zero path: DONE is entered straight from IDLE, so the pulse
                // is raised on the way out, one edge after acceptance.
                if (zero_pend_q) begin
                    done_d      = 1'b1;
                    zflag_d     = 1'b1;
                    zero_pend_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_pend_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            zero_pend_q <= zero_pend_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zflag_q     <= zflag_d;
        end
    end

    assign Div_HIOut = hi_q;
    assign Div_LOOut = lo_q;
    assign Div_Busy  = busy_q;
    assign Div_Done  = done_q;
    assign Div_Zero  = zflag_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed bench for div_unit. Drivers push the hand-computed response into
// expected queues when a start is accepted; a monitor pops and compares on
// every Div_Done pulse (values, zero flag, busy, and arrival cycle).
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        Clock;
    logic        Reset;
    logic        Div_Start;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic [31:0] Div_HIOut;
    logic [31:0] Div_LOOut;
    logic        Div_Busy;
    logic        Div_Done;
    logic        Div_Zero;
    logic [1:0]  dbg_state;

    div_unit #(.DATA_WIDTH(32)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Div_Start (Div_Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Div_HIOut (Div_HIOut),
        .Div_LOOut (Div_LOOut),
        .Div_Busy  (Div_Busy),
        .Div_Done  (Div_Done),
        .Div_Zero  (Div_Zero),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_lo_q[$];
    logic [31:0] exp_hi_q[$];
    logic        exp_z_q[$];
    int          exp_cyc_q[$];

    int applied    = 0;
    int miscompare = 0;
    int done_seen  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompare++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (Div_Done === 1'b1) begin
            done_seen++;
            if (exp_lo_q.size() == 0) begin
                applied++;
                miscompare++;
                $display("FAIL unexpected_done: got Div_Done=1 expected none (t=%0t)", $time);
            end else begin
                check32("done_lo",    Div_LOOut, exp_lo_q.pop_front());
                check32("done_hi",    Div_HIOut, exp_hi_q.pop_front());
                check32("done_zero",  {31'd0, Div_Zero}, {31'd0, exp_z_q.pop_front()});
                check32("done_busy",  {31'd0, Div_Busy}, 32'd0);
                check32("done_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // Issue one start; returns the accept cycle count as seen by the monitor.
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, output int t);
        @(negedge Clock);
        Dividend  = a;
        Divisor   = b;
        Div_Start = 1'b1;
        @(negedge Clock);
        Div_Start = 1'b0;
        t = cyc;
    endtask

    // Wait (bounded) for done_seen to move past n0; returns whether busy was seen.
    task automatic wait_done(input int n0, output logic busy_seen);
        int k;
        busy_seen = 1'b0;
        k = 0;
        while (done_seen == n0 && k < 60) begin
            @(posedge Clock);
            #1;
            if (Div_Busy === 1'b1) busy_seen = 1'b1;
            k++;
        end
        @(negedge Clock);
        check32("done_timeout", {31'd0, done_seen != n0}, 32'd1);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_lo, input logic [31:0] e_hi,
                           input logic e_z);
        int   t;
        int   n0;
        logic busy_seen;
        n0 = done_seen;
        pulse_start(a, b, t);
        exp_lo_q.push_back(e_lo);
        exp_hi_q.push_back(e_hi);
        exp_z_q.push_back(e_z);
        exp_cyc_q.push_back(t + (e_z ? 1 : 33));
        wait_done(n0, busy_seen);
        if (e_z) check32("zero_busy_never", {31'd0, busy_seen}, 32'd0);
        // Results hold after the pulse.
        @(negedge Clock);
        check32("hold_lo", Div_LOOut, e_lo);
        check32("hold_hi", Div_HIOut, e_hi);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   t;
        int   n0;
        logic busy_seen;

        Reset     = 1'b0;
        Div_Start = 1'b0;
        Dividend  = '0;
        Divisor   = '0;
        #12;
        check32("rst_lo",    Div_LOOut, 32'd0);
        check32("rst_hi",    Div_HIOut, 32'd0);
        check32("rst_busy",  {31'd0, Div_Busy}, 32'd0);
        check32("rst_done",  {31'd0, Div_Done}, 32'd0);
        check32("rst_zero",  {31'd0, Div_Zero}, 32'd0);
        check32("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;

        // Basic and signed divides.
        run_div(32'd7,          32'd2,          32'd3,          32'd1,          1'b0);
        run_div(32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_div(32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
        run_div(32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0);

        // Divide-by-zero keeps the preloaded HI/LO.
        run_div(32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        run_div(32'd5,          32'd0,          32'd14,         32'd2,          1'b1);

        // Overflow and edge operands.
        run_div(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
        run_div(32'd0,          32'd5,          32'd0,          32'd0,          1'b0);
        run_div(32'd3,          32'h7FFF_FFFF,  32'd0,          32'd3,          1'b0);

        // Start while busy: second start and operand changes are ignored.
        n0 = done_seen;
        pulse_start(32'd7, 32'd2, t);
        exp_lo_q.push_back(32'd3);
        exp_hi_q.push_back(32'd1);
        exp_z_q.push_back(1'b0);
        exp_cyc_q.push_back(t + 33);
        repeat (9) @(negedge Clock);
        Dividend  = 32'd9;
        Divisor   = 32'd4;
        Div_Start = 1'b1;
        @(negedge Clock);
        Div_Start = 1'b0;
        Dividend  = 32'hDEAD_BEEF;
        Divisor   = 32'd0;
        wait_done(n0, busy_seen);
        repeat (40) @(negedge Clock);
        check32("busy_start_single_done", done_seen - n0, 32'd1);
        run_div(32'd9,          32'd4,          32'd2,          32'd1,          1'b0);

        // Reset mid-operation: asynchronous, between edges.
        n0 = done_seen;
        pulse_start(32'd7, 32'd2, t);
        repeat (14) @(negedge Clock);
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        #1;
        check32("mid_rst_busy",  {31'd0, Div_Busy}, 32'd0);
        check32("mid_rst_lo",    Div_LOOut, 32'd0);
        check32("mid_rst_hi",    Div_HIOut, 32'd0);
        check32("mid_rst_state", {30'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        repeat (40) @(negedge Clock);
        check32("mid_rst_no_done", done_seen - n0, 32'd0);
        run_div(32'd7,          32'd2,          32'd3,          32'd1,          1'b0);

        check32("queue_drained", exp_lo_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompare);
        $finish;
    end

endmodule
